// File: rtl/d2l_pkg.sv
// Shared D2L definitions: FSM state encoding, width limit and the
// frame-length helper used by both the transmitter and the receiver.
package d2l_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } d2l_state_e;

  localparam int unsigned D2L_MAX_WIDTH = 128;

  function automatic int unsigned d2l_cycles(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/d2l_tx_shiftreg.sv
// Payload register for the D2L transmitter: parallel load, 2-bit left shift,
// top two bits exposed as the next pair to drive onto the link.
module d2l_tx_shiftreg #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [1:0]            o_top
);

  logic [DATA_WIDTH-1:0] r_sr;

  always_ff @(posedge sclk) begin
    if (rst)          r_sr <= '0;
    else if (i_load)  r_sr <= i_data;
    else if (i_shift) r_sr <= r_sr << 2;
  end

  assign o_top = r_sr[DATA_WIDTH-1 -: 2];

endmodule

// File: rtl/d2l_master_tx.sv
// D2L transmitter: frames a DATA_WIDTH word with active-low CS and sends it
// MSB pair first on OutLine1/OutLine0, one pair per sclk, all on the rising edge.
module d2l_master_tx
  import d2l_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  ready,
  output logic                  done,
  output logic                  CS,
  output logic                  OutLine1,
  output logic                  OutLine0
);

  localparam int unsigned N   = d2l_cycles(DATA_WIDTH);
  localparam int unsigned PCW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GCW = $clog2(GAP_CYCLES + 1);

  if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH > D2L_MAX_WIDTH || DATA_WIDTH < 2) begin : g_bad_width
    $error("d2l_master_tx: DATA_WIDTH must be even and within 2..%0d", D2L_MAX_WIDTH);
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("d2l_master_tx: GAP_CYCLES must be at least 1");
  end

  d2l_state_e     r_state, w_state_nxt;
  logic [PCW-1:0] r_pair,  w_pair_nxt;
  logic [GCW-1:0] r_gap,   w_gap_nxt;
  logic           r_cs,    w_cs_nxt;
  logic [1:0]     r_lines, w_lines_nxt;
  logic           r_done,  w_done_nxt;
  logic           w_load, w_shift;
  logic [1:0]     w_top;

  d2l_tx_shiftreg #(.DATA_WIDTH(DATA_WIDTH)) u_sr (
    .sclk    (sclk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (DATA_IN),
    .o_top   (w_top)
  );

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pair  <= '0;
      r_gap   <= '0;
      r_cs    <= 1'b1;
      r_lines <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pair  <= w_pair_nxt;
      r_gap   <= w_gap_nxt;
      r_cs    <= w_cs_nxt;
      r_lines <= w_lines_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // The pair loaded on an edge is taken from the shift register before that
  // same edge shifts it, so SETUP's exit edge already presents pair 0.
  always_comb begin
    w_state_nxt = r_state;
    w_pair_nxt  = r_pair;
    w_gap_nxt   = r_gap;
    w_cs_nxt    = r_cs;
    w_lines_nxt = r_lines;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cs_nxt    = 1'b1;
        w_lines_nxt = '0;
        if (start) begin
          w_load      = 1'b1;
          w_cs_nxt    = 1'b0;
          w_pair_nxt  = '0;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_lines_nxt = w_top;
        w_shift     = 1'b1;
        w_pair_nxt  = '0;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (r_pair == PCW'(N - 1)) begin
          w_cs_nxt    = 1'b1;
          w_lines_nxt = '0;
          w_gap_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else begin
          w_lines_nxt = w_top;
          w_shift     = 1'b1;
          w_pair_nxt  = r_pair + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap == GCW'(GAP_CYCLES - 1)) begin
          w_done_nxt  = 1'b1;
          w_gap_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt   = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ready    = (r_state == ST_IDLE);
  assign done     = r_done;
  assign CS       = r_cs;
  assign OutLine1 = r_lines[1];
  assign OutLine0 = r_lines[0];

endmodule
